// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// Size encodings, FSM states and CPU store/load opcode helpers.
package dmem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RMW_WR,
    RESP
  } state_t;

  function automatic logic [1:0] op2size(input logic [5:0] op);
    logic [1:0] sz;
    sz = SZ_WORD;
    unique case (1'b1)
      (op == OP_SB): sz = SZ_BYTE;
      (op == OP_SH): sz = SZ_HALF;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_picker.sv
// Two-port request picker; round-robin when DMEM_ARB_RR_EN is defined,
// fixed priority (port 0 first) otherwise.
module dmem_rr_picker (
  input  logic [1:0] i_valid,
`ifdef DMEM_ARB_RR_EN
  input  logic       i_last,
`endif
  output logic [1:0] o_grant
);

`ifdef DMEM_ARB_RR_EN
  // On contention favour the port that was not granted last
  always_comb begin
    o_grant = i_valid;
    if (&i_valid)
      o_grant = i_last ? 2'b01 : 2'b10;
  end
`else
  always_comb begin
    o_grant = 2'b00;
    if (i_valid[0])
      o_grant = 2'b01;
    else if (i_valid[1])
      o_grant = 2'b10;
  end
`endif

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between CPU (port 0) and debug (port 1).
// Sub-word stores run as read-modify-write; DMEM_ARB_RR_EN selects round-robin.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [3:0]          req_size,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t              r_state;
  logic                r_owner;
  logic                r_write;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic [1:0]          w_win;
  logic                w_accept;
  logic                w_port;
  logic                w_rmw;
  logic [DATA_W-1:0]   w_merge;

`ifdef DMEM_ARB_RR_EN
  logic r_last;

  dmem_rr_picker u_pick (
    .i_valid (req_valid),
    .i_last  (r_last),
    .o_grant (w_win)
  );
`else
  dmem_rr_picker u_pick (
    .i_valid (req_valid),
    .o_grant (w_win)
  );
`endif

  assign w_accept = (r_state == IDLE) && (|w_win);
  assign w_port   = w_win[1];
  assign w_rmw    = r_write &&
                    ((r_size == SZ_BYTE) || (r_size == SZ_HALF));

  always_comb begin
    w_merge = mem_rdata;
    if (r_size == SZ_BYTE)
      w_merge[7:0] = r_wdata[7:0];
    else
      w_merge[15:0] = r_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef DMEM_ARB_RR_EN
      r_last  <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner <= w_port;
            r_write <= req_write[w_port];
            r_size  <= w_port ? req_size[3:2] : req_size[1:0];
            r_addr  <= w_port ? req_addr[2*ADDR_W-1:ADDR_W]
                              : req_addr[ADDR_W-1:0];
            r_wdata <= w_port ? req_wdata[2*DATA_W-1:DATA_W]
                              : req_wdata[DATA_W-1:0];
`ifdef DMEM_ARB_RR_EN
            r_last  <= w_port;
`endif
            r_state <= ISSUE;
          end
        end
        ISSUE:  r_state <= w_rmw ? RMW_WR : RESP;
        RMW_WR: r_state <= RESP;
        RESP: begin
          if (!r_write)
            r_rdata <= mem_rdata;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (reset_n && r_state == IDLE) ? w_win : 2'b00;

  assign mem_en = reset_n &&
                  ((r_state == ISSUE) || (r_state == RMW_WR));
  assign mem_we = reset_n &&
                  (((r_state == ISSUE) && r_write && !w_rmw) ||
                   (r_state == RMW_WR));

  assign mem_addr  = mem_en ? r_addr : '0;
  assign mem_wdata = !mem_we ? '0 :
                     (r_state == RMW_WR) ? w_merge : r_wdata;

  assign rsp_valid = (reset_n && r_state == RESP) ?
                     (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (r_state == RESP && !r_write) ? mem_rdata : r_rdata;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a behavioural 1-cycle memory.
// Arbitration expectations follow DMEM_ARB_RR_EN.
module tb_dmem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [3:0]  req_size;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [256];
  logic        pk_we = 1'b0;
  logic [7:0]  pk_addr = '0;
  logic [31:0] pk_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (pk_we)
      mem[pk_addr] <= pk_data;
    else if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pk_we = 1'b1;
    pk_addr = a;
    pk_data = d;
    step();
    pk_we = 1'b0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] d);
    req_valid[p]      = 1'b1;
    req_write[p]      = w;
    req_size[2*p+:2]  = sz;
    req_addr[8*p+:8]  = a;
    req_wdata[32*p+:32] = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_write = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (req_ready == 2'b00 && n < lim) begin
      step();
      n++;
    end
    chk("ready_seen", {31'b0, |req_ready}, 32'd1);
  endtask

  logic [1:0] exp_g [4];

  initial begin
    clear_req();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_rsp",   {30'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_en",    {31'b0, mem_en}, 32'd0);
    chk("rst_we",    {31'b0, mem_we}, 32'd0);
    chk("rst_addr",  {24'b0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    step();

    // word store then load at addr 5
    set_req(0, 1'b1, 2'b10, 8'd5, 32'hDEADBEEF);
    #1;
    chk("sw_ready", {30'b0, req_ready}, 32'd1);
    step();
    clear_req();
    chk("sw_en",    {31'b0, mem_en}, 32'd1);
    chk("sw_we",    {31'b0, mem_we}, 32'd1);
    chk("sw_addr",  {24'b0, mem_addr}, 32'd5);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("sw_rsp",   {30'b0, rsp_valid}, 32'd1);
    chk("sw_en2",   {31'b0, mem_en}, 32'd0);
    step();
    chk("sw_mem",   mem[5], 32'hDEADBEEF);
    set_req(0, 1'b0, 2'b10, 8'd5, 32'h0);
    #1;
    chk("lw_ready", {30'b0, req_ready}, 32'd1);
    step();
    clear_req();
    chk("lw_en",    {31'b0, mem_en}, 32'd1);
    chk("lw_we",    {31'b0, mem_we}, 32'd0);
    step();
    chk("lw_rsp",   {30'b0, rsp_valid}, 32'd1);
    chk("lw_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    chk("lw_hold",  rsp_rdata, 32'hDEADBEEF);

    // port 1 byte then half store at addr 7
    poke(8'd7, 32'h11223344);
    set_req(1, 1'b1, 2'b00, 8'd7, 32'hFFFFFFAA);
    #1;
    chk("sb_ready", {30'b0, req_ready}, 32'd2);
    step();
    clear_req();
    chk("sb_rd_en", {31'b0, mem_en}, 32'd1);
    chk("sb_rd_we", {31'b0, mem_we}, 32'd0);
    chk("sb_addr",  {24'b0, mem_addr}, 32'd7);
    step();
    chk("sb_wr_we", {31'b0, mem_we}, 32'd1);
    chk("sb_wdata", mem_wdata, 32'h112233AA);
    chk("sb_norsp", {30'b0, rsp_valid}, 32'd0);
    step();
    chk("sb_rsp",   {30'b0, rsp_valid}, 32'd2);
    chk("sb_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    chk("sb_mem",   mem[7], 32'h112233AA);
    set_req(1, 1'b1, 2'b01, 8'd7, 32'h5555BEEF);
    #1;
    step();
    clear_req();
    step();
    chk("sh_wdata", mem_wdata, 32'h1122BEEF);
    step();
    chk("sh_rsp",   {30'b0, rsp_valid}, 32'd2);
    step();
    chk("sh_mem",   mem[7], 32'h1122BEEF);

    // both ports request continuously
`ifdef DMEM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10;
    exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01;
    exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    set_req(0, 1'b0, 2'b10, 8'd5, 32'h0);
    set_req(1, 1'b0, 2'b10, 8'd7, 32'h0);
    for (int g = 0; g < 4; g++) begin
      #1;
      wait_ready(8);
      chk($sformatf("grant%0d", g), {30'b0, req_ready}, {30'b0, exp_g[g]});
      step();
    end
    clear_req();
    step();
    step();
    step();

    // reset during the write phase of a byte store
    poke(8'd9, 32'hCAFEF00D);
    set_req(0, 1'b1, 2'b00, 8'd9, 32'h000000EE);
    #1;
    chk("rb_ready", {30'b0, req_ready}, 32'd1);
    step();
    clear_req();
    step();
    reset_n = 1'b0;
    #1;
    chk("rb_we",    {31'b0, mem_we}, 32'd0);
    chk("rb_en",    {31'b0, mem_en}, 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk("rb_rsp",   {30'b0, rsp_valid}, 32'd0);
    chk("rb_rdata", rsp_rdata, 32'd0);
    chk("rb_en2",   {31'b0, mem_en}, 32'd0);
    chk("rb_mem",   mem[9], 32'hCAFEF00D);
    step();
    chk("rb_rsp2",  {30'b0, rsp_valid}, 32'd0);
    chk("rb_mem2",  mem[9], 32'hCAFEF00D);
    set_req(0, 1'b0, 2'b10, 8'd5, 32'h0);
    set_req(1, 1'b0, 2'b10, 8'd7, 32'h0);
    #1;
    chk("rb_grant", {30'b0, req_ready}, 32'd1);
    clear_req();
    step();

    // size 2'b11 behaves as a word store
    set_req(0, 1'b1, 2'b11, 8'd12, 32'h12345678);
    #1;
    chk("s3_ready", {30'b0, req_ready}, 32'd1);
    step();
    clear_req();
    chk("s3_we",    {31'b0, mem_we}, 32'd1);
    chk("s3_wdata", mem_wdata, 32'h12345678);
    step();
    chk("s3_rsp",   {30'b0, rsp_valid}, 32'd1);
    step();
    chk("s3_mem",   mem[12], 32'h12345678);
    chk("s3_idle",  {31'b0, mem_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_access_arbiter.md
# dmem_access_arbiter

Synchronous controller sharing the single-port 256-word data memory between two requesters: port 0, the CPU load/store stage, and port 1, the debug/loader port. It accepts one request at a time with a valid/ready handshake and drives the memory's enable, write-enable, address and data. Byte and halfword stores become a two-access read-modify-write so the memory itself only performs full-word writes. Each request is answered with a one-cycle response pulse to the requester that issued it.

## Interface
- ADDR_W, 8, word-address width (256 words)
- DATA_W, 32, data width; byte/half merge assumes 32
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  2  per-port request valid, bit i = port i
- req_write  in  2  per-port 1 = store, 0 = load
- req_size  in  4  per-port size, bits [2i+1:2i]: 00 byte, 01 half, 10 word, 11 treated as word
- req_addr  in  2*ADDR_W  per-port word address, slice i
- req_wdata  in  2*DATA_W  per-port store data, slice i
- req_ready  out  2  one-hot grant; request accepted on valid & ready
- rsp_valid  out  2  one-hot, one-cycle response pulse to the owning port
- rsp_rdata  out  DATA_W  load data, qualified by rsp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe, only with mem_en
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe

## Operation
- States: IDLE, ISSUE, RMW_WR, RESP.
- IDLE: req_ready is driven combinationally to the arbitration winner among the valid ports; it is 0 in all other states. On acceptance, latch port id, write, size, addr and wdata, then go to ISSUE.
- ISSUE: mem_en = 1 and mem_addr = latched address.
  - Load, or word store with mem_we = 1 and mem_wdata = wdata: go to RESP.
  - Byte or half store: mem_we = 0 (read phase), go to RMW_WR.
- RMW_WR: mem_en = 1, mem_we = 1.
  - mem_wdata = mem_rdata with bits [7:0] replaced for a byte store, or bits [15:0] for a half store, taken from the low bits of wdata.
  - Go to RESP.
- RESP: rsp_valid[owner] = 1. For a load, rsp_rdata = mem_rdata captured in this cycle, held until the next load response. For a store, rsp_rdata is unchanged. Go to IDLE.
- Arbitration: round-robin (see Configuration). The last_grant register updates only on acceptance.
- Requesters hold req_* stable while valid & !ready. The arbiter never withdraws ready within a cycle.
- No per-request address validation: the full ADDR_W range is legal.

## Timing
- Load or word store: accept at T, memory access at T+1, rsp_valid at T+2, next accept at T+3 at the earliest.
- Byte/half store: accept T, read T+1, write T+2, rsp_valid T+3, next accept T+4.
- Memory read latency is exactly 1 cycle; RMW_WR and RESP sample mem_rdata directly with no extra register.
- Reset (reset_n low at an edge): state becomes IDLE, last_grant becomes 1 (port 0 wins first), rsp_rdata becomes 0, and latched fields become 0.
- Reset values in IDLE with no valid requests: all outputs are 0.
- mem_en and mem_we are ANDed with reset_n, so no memory access occurs in any cycle where reset_n is low, including mid-RMW. An in-flight request is dropped without a response.
- When both ports are valid in the same IDLE cycle, exactly one req_ready bit is set. The loser sees ready at its next IDLE cycle.
- A new request arriving during a response is not accepted until IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On contention the port not granted last wins.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins on contention. The last_grant register is not implemented. Port 1 can starve under a continuous port-0 stream.

## Structure
- Package dmem_arb_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - opcode constants OP_LW 6'h23, OP_SB 6'h28, OP_SH 6'h29, OP_SW 6'h2B
  - a function mapping opcode to size, used by the CPU port decoder
- Sub-module dmem_rr_picker: inputs are the 2-bit valid vector and last_grant; output is a one-hot winner. It contains the macro-selected policy.
- Byte/half merge is inline in the arbiter.

## Test plan
- Port 0 writes word 0xDEADBEEF to addr 5, then loads addr 5 -> mem_we pulse at T+1; load rsp_valid[0] at its T+2 with rsp_rdata = 0xDEADBEEF.
- Addr 7 holds 0x11223344; port 1 byte store of 0xAA -> read at T+1, write 0x112233AA at T+2, rsp_valid[1] at T+3. Then a half store of 0xBEEF gives 0x1122BEEF.
- Both ports request continuously, RR enabled -> grants alternate 0,1,0,1. Build without the macro -> port 0 granted every time, port 1 never.
- reset_n low during the RMW_WR cycle of a byte store to addr 9 -> mem_we stays 0 and addr 9 is unchanged. No rsp_valid; all outputs 0; next grant goes to port 0.
- size 2'b11 store of 0x12345678 -> single full-word write, latency identical to a word store.
